// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and width helpers for the fifo_flex block.
// Holds the default parameter values and the functions that size the level
// counter and the storage pointers. Contains no per-instance state.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH        = 8;
  localparam int DEF_DEPTH             = 8;
  localparam int DEF_ALMOSTFULL_DEPTH  = 3;
  localparam int DEF_ALMOSTEMPTY_DEPTH = 3;
  localparam int DEF_SHOW_AHEAD        = 0;

  // Level must represent 0..DEPTH inclusive, hence one bit more than the pointer.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Pointer width; DEPTH is a power of two >= 2, so pointers wrap naturally.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_flex_if.sv
// fifo_flex_if: push/pop handshake and status bundle for fifo_flex.
//   write, write_data : push request and word
//   read, read_data   : pop request and popped/head word
//   empty, full, almost_empty, almost_full, level : occupancy status
//   overflow, underflow : sticky error flags
// master = the user of the FIFO, slave = the FIFO itself.
interface fifo_flex_if #(
  parameter int DATA_WIDTH = fifo_pkg::DEF_DATA_WIDTH,
  parameter int DEPTH      = fifo_pkg::DEF_DEPTH
);
  import fifo_pkg::*;

  logic                          write;
  logic [DATA_WIDTH-1:0]         write_data;
  logic                          read;
  logic [DATA_WIDTH-1:0]         read_data;
  logic                          empty;
  logic                          full;
  logic                          almost_empty;
  logic                          almost_full;
  logic [level_width(DEPTH)-1:0] level;
  logic                          overflow;
  logic                          underflow;

  modport master (
    output write, write_data, read,
    input  read_data, empty, full, almost_empty, almost_full, level, overflow, underflow
  );

  modport slave (
    input  write, write_data, read,
    output read_data, empty, full, almost_empty, almost_full, level, overflow, underflow
  );

endinterface

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port storage for fifo_flex.
// Synchronous write, asynchronous read, no reset on the array.
//   clk   : write clock
//   we    : write enable, waddr/wdata : write port
//   raddr : read address, rdata : combinational read word
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/fifo_flex.sv
// fifo_flex: single-clock parameterised FIFO with registered status flags.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   clear : synchronous flush, overrides write/read in the same cycle
//   bus   : fifo_flex_if slave (push/pop handshake, data, status, errors)
// SHOW_AHEAD=0 registers the popped word; SHOW_AHEAD=1 exposes the head word.
module fifo_flex
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter int DEPTH             = DEF_DEPTH,
  parameter int ALMOSTFULL_DEPTH  = DEF_ALMOSTFULL_DEPTH,
  parameter int ALMOSTEMPTY_DEPTH = DEF_ALMOSTEMPTY_DEPTH,
  parameter int SHOW_AHEAD        = DEF_SHOW_AHEAD
) (
  input logic        clk,
  input logic        reset,
  input logic        clear,
  fifo_flex_if.slave bus
);

  localparam int PW = ptr_width(DEPTH);
  localparam int LW = level_width(DEPTH);

  localparam logic [LW-1:0] ZERO_LEVEL = LW'(1'b0);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LEVEL   = LW'(DEPTH - ALMOSTFULL_DEPTH);
  localparam logic [LW-1:0] AE_LEVEL   = LW'(ALMOSTEMPTY_DEPTH);

  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [LW-1:0]         level_r;
  logic [LW-1:0]         level_nxt_s;
  logic                  empty_r;
  logic                  full_r;
  logic                  almost_empty_r;
  logic                  almost_full_r;
  logic                  overflow_r;
  logic                  underflow_r;
  logic                  rd_ok_s;
  logic                  wr_ok_s;
  logic [DATA_WIDTH-1:0] ram_rdata_s;

  // A read on empty is dropped even if a write arrives with it; a write on
  // full is accepted only when a read frees the slot in the same cycle.
  assign rd_ok_s = bus.read && !empty_r;
  assign wr_ok_s = bus.write && (!full_r || rd_ok_s);

  // Next occupancy; clear wins over any transfer.
  always_comb begin
    level_nxt_s = level_r;
    if (clear) begin
      level_nxt_s = ZERO_LEVEL;
    end else begin
      case ({wr_ok_s, rd_ok_s})
        2'b10:   level_nxt_s = level_r + LW'(1'b1);
        2'b01:   level_nxt_s = level_r - LW'(1'b1);
        default: level_nxt_s = level_r;
      endcase
    end
  end

  // Pointers, occupancy, status flags and sticky error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r       <= {PW{1'b0}};
      rd_ptr_r       <= {PW{1'b0}};
      level_r        <= ZERO_LEVEL;
      empty_r        <= 1'b1;
      full_r         <= 1'b0;
      almost_empty_r <= 1'b1;
      almost_full_r  <= 1'b0;
      overflow_r     <= 1'b0;
      underflow_r    <= 1'b0;
    end else begin
      // Flags derive from the next level so they land on the same edge.
      level_r        <= level_nxt_s;
      empty_r        <= (level_nxt_s == ZERO_LEVEL);
      full_r         <= (level_nxt_s == FULL_LEVEL);
      almost_empty_r <= (level_nxt_s <= AE_LEVEL);
      almost_full_r  <= (level_nxt_s >= AF_LEVEL);
      if (clear) begin
        wr_ptr_r    <= {PW{1'b0}};
        rd_ptr_r    <= {PW{1'b0}};
        overflow_r  <= 1'b0;
        underflow_r <= 1'b0;
      end else begin
        if (wr_ok_s) begin
          wr_ptr_r <= wr_ptr_r + PW'(1'b1);
        end
        if (rd_ok_s) begin
          rd_ptr_r <= rd_ptr_r + PW'(1'b1);
        end
        if (bus.write && !wr_ok_s) begin
          overflow_r <= 1'b1;
        end
        if (bus.read && !rd_ok_s) begin
          underflow_r <= 1'b1;
        end
      end
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (PW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok_s && !clear),
    .waddr (wr_ptr_r),
    .wdata (bus.write_data),
    .raddr (rd_ptr_r),
    .rdata (ram_rdata_s)
  );

  if (SHOW_AHEAD == 0) begin : g_registered
    logic [DATA_WIDTH-1:0] rd_data_r;

    // Popped word register: loads the head on an accepted read, else holds.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd_data_r <= {DATA_WIDTH{1'b0}};
      end else if (clear) begin
        rd_data_r <= {DATA_WIDTH{1'b0}};
      end else if (rd_ok_s) begin
        rd_data_r <= ram_rdata_s;
      end
    end

    assign bus.read_data = rd_data_r;
  end else begin : g_show_ahead
    // Head word is visible directly; meaningless while empty.
    assign bus.read_data = ram_rdata_s;
  end

  assign bus.level        = level_r;
  assign bus.empty        = empty_r;
  assign bus.full         = full_r;
  assign bus.almost_empty = almost_empty_r;
  assign bus.almost_full  = almost_full_r;
  assign bus.overflow     = overflow_r;
  assign bus.underflow    = underflow_r;

endmodule

// File: tb/tb_fifo_flex.sv
// tb_fifo_flex: scoreboard bench for fifo_flex.
// A registered-read instance is driven through directed sequences while a
// bench-side queue model predicts status; popped words are pushed into a
// scoreboard and a separate monitor compares them after each read edge.
// A second, show-ahead instance gets its own directed checks.
module tb_fifo_flex;
  import fifo_pkg::*;

  localparam int DW = 8;
  localparam int DP = 8;
  localparam int AF = 3;
  localparam int AE = 3;

  logic clk = 1'b0;
  logic reset;
  logic clear;
  logic clear_sa;

  always #5 clk = ~clk;

  fifo_flex_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();
  fifo_flex_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus_sa ();

  fifo_flex #(
    .DATA_WIDTH(DW), .DEPTH(DP), .ALMOSTFULL_DEPTH(AF),
    .ALMOSTEMPTY_DEPTH(AE), .SHOW_AHEAD(0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus.slave)
  );

  fifo_flex #(
    .DATA_WIDTH(DW), .DEPTH(DP), .ALMOSTFULL_DEPTH(AF),
    .ALMOSTEMPTY_DEPTH(AE), .SHOW_AHEAD(1)
  ) dut_sa (
    .clk   (clk),
    .reset (reset),
    .clear (clear_sa),
    .bus   (bus_sa.slave)
  );

  int vectors = 0;
  int errors  = 0;

  logic [DW-1:0] model_q [$];
  logic [DW-1:0] sb_q [$];
  logic [DW-1:0] mon_exp;
  logic          m_ovf;
  logic          m_udf;
  logic          rd_expect;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_status();
    int n;
    n = model_q.size();
    check("level",        32'(bus.level),        32'(n));
    check("empty",        32'(bus.empty),        32'(n == 0));
    check("full",         32'(bus.full),         32'(n == DP));
    check("almost_empty", 32'(bus.almost_empty), 32'(n <= AE));
    check("almost_full",  32'(bus.almost_full),  32'(n >= DP - AF));
    check("overflow",     32'(bus.overflow),     32'(m_ovf));
    check("underflow",    32'(bus.underflow),    32'(m_udf));
  endtask

  // One cycle of stimulus on the registered-read instance.
  task automatic step(input logic wr, input logic [DW-1:0] wd, input logic rd, input logic clr);
    bit rd_ok;
    bit wr_ok;
    @(negedge clk);
    bus.write      = wr;
    bus.write_data = wd;
    bus.read       = rd;
    clear          = clr;
    rd_ok = rd && (model_q.size() > 0);
    wr_ok = wr && ((model_q.size() < DP) || rd_ok);
    rd_expect = rd_ok && !clr;
    if (clr) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (wr && !wr_ok) m_ovf = 1'b1;
      if (rd && !rd_ok) m_udf = 1'b1;
      if (rd_ok) sb_q.push_back(model_q.pop_front());
      if (wr_ok) model_q.push_back(wd);
    end
    @(posedge clk);
    #1;
    check_status();
  endtask

  task automatic idle();
    @(negedge clk);
    bus.write = 1'b0;
    bus.read  = 1'b0;
    clear     = 1'b0;
    rd_expect = 1'b0;
  endtask

  // Monitor: after each edge where a read was accepted, compare the popped word.
  always @(posedge clk) begin
    if (rd_expect) begin
      #1;
      if (sb_q.size() == 0) begin
        check("sb_underrun", 32'd1, 32'd0);
      end else begin
        mon_exp = sb_q.pop_front();
        check("read_data", 32'(bus.read_data), 32'(mon_exp));
      end
    end
  end

  initial begin
    reset = 1'b0;
    clear = 1'b0;
    clear_sa = 1'b0;
    rd_expect = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    bus.write = 1'b0; bus.write_data = 8'h00; bus.read = 1'b0;
    bus_sa.write = 1'b0; bus_sa.write_data = 8'h00; bus_sa.read = 1'b0;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1;
    check_status();
    check("read_data_rst", 32'(bus.read_data), 32'd0);
    check("sa_empty_rst", 32'(bus_sa.empty), 32'd1);
    check("sa_level_rst", 32'(bus_sa.level), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Fill with 0..9: 8 and 9 are dropped and raise overflow.
    for (int i = 0; i < 10; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    // Drain 10 times: 0..7 then underflow.
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    idle();

    // Flush the sticky flags, then full pass-through.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("read_data_clr", 32'(bus.read_data), 32'd0);
    for (int i = 16; i < 24; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    step(1'b1, 8'd24, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Interleaved traffic across the pointer wrap.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
      step(1'b1, DW'(8'h60 + i), 1'b1, 1'b0);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    idle();

    // Clear mid-operation at level 5 with overflow set; the write is dropped.
    for (int i = 0; i < 9; i++) step(1'b1, DW'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b1);
    check("read_data_clr2", 32'(bus.read_data), 32'd0);
    idle();

    // Reset mid-operation at level 5 with overflow set: immediate effect.
    for (int i = 0; i < 9; i++) step(1'b1, DW'(8'hC0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    rd_expect = 1'b0;
    bus.write = 1'b1;
    bus.write_data = 8'hBB;
    bus.read = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check_status();
    check("read_data_arst", 32'(bus.read_data), 32'd0);
    @(negedge clk);
    bus.write = 1'b0;
    reset = 1'b1;
    // Contents discarded: a fresh word comes out first.
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    idle();

    // Show-ahead instance: head visible without a read.
    @(negedge clk);
    bus_sa.write = 1'b1; bus_sa.write_data = 8'h10;
    @(negedge clk);
    bus_sa.write = 1'b0;
    check("sa_head_10",  32'(bus_sa.read_data), 32'h10);
    check("sa_level_1",  32'(bus_sa.level),     32'd1);
    check("sa_empty_0",  32'(bus_sa.empty),     32'd0);
    bus_sa.read = 1'b1;
    @(negedge clk);
    bus_sa.read = 1'b0;
    check("sa_empty_1",  32'(bus_sa.empty),     32'd1);
    check("sa_level_0",  32'(bus_sa.level),     32'd0);
    bus_sa.write = 1'b1; bus_sa.write_data = 8'h21;
    @(negedge clk);
    bus_sa.write_data = 8'h22;
    @(negedge clk);
    bus_sa.write = 1'b0;
    check("sa_head_21",  32'(bus_sa.read_data), 32'h21);
    check("sa_level_2",  32'(bus_sa.level),     32'd2);
    bus_sa.read = 1'b1;
    @(negedge clk);
    bus_sa.read = 1'b0;
    check("sa_head_22",  32'(bus_sa.read_data), 32'h22);
    check("sa_level_1b", 32'(bus_sa.level),     32'd1);
    clear_sa = 1'b1;
    @(negedge clk);
    clear_sa = 1'b0;
    check("sa_clr_lvl",  32'(bus_sa.level),     32'd0);
    check("sa_clr_emp",  32'(bus_sa.empty),     32'd1);

    repeat (2) @(negedge clk);
    check("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
